// File: rtl/traffic_pkg.sv
// Light encodings, one-hot controller states and the light decode
// shared by the intersection controller and its testbench.
package traffic_pkg;

  typedef enum logic [1:0] {
    LT_RED    = 2'd0,
    LT_GREEN  = 2'd1,
    LT_YELLOW = 2'd2,
    LT_OFF    = 2'd3
  } light_t;

  typedef enum logic [6:0] {
    S_EW_GREEN  = 7'b000_0001,
    S_EW_YELLOW = 7'b000_0010,
    S_ALLRED_A  = 7'b000_0100,
    S_NS_GREEN  = 7'b000_1000,
    S_NS_YELLOW = 7'b001_0000,
    S_ALLRED_B  = 7'b010_0000,
    S_FLASH     = 7'b100_0000
  } state_t;

  typedef struct packed {
    light_t ew;
    light_t ns;
  } lights_t;

  function automatic lights_t state_lights(
    input state_t s,
    input logic   blink_off
  );
    lights_t l;
    l.ew = LT_RED;
    l.ns = LT_RED;
    case (s)
      S_EW_GREEN:  l.ew = LT_GREEN;
      S_EW_YELLOW: l.ew = LT_YELLOW;
      S_NS_GREEN:  l.ns = LT_GREEN;
      S_NS_YELLOW: l.ns = LT_YELLOW;
      S_FLASH: begin
        l.ew = blink_off ? LT_OFF : LT_YELLOW;
        l.ns = blink_off ? LT_OFF : LT_YELLOW;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each controller phase; holds at zero
// when not reloaded.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with all-red clearance, pedestrian
// walk phase, night flash mode and a phase countdown output.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int GREEN_CYCLES  = 25,
  parameter int YELLOW_CYCLES = 5,
  parameter int ALLRED_CYCLES = 2,
  parameter int MIN_GREEN     = 10,
  parameter int WALK_CYCLES   = 8,
  parameter int FLASH_HALF    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             flash,
  output logic [1:0]       e_west,
  output logic [1:0]       s_north,
  output logic             ped_walk,
  output logic [CNT_W-1:0] remain
);

  localparam longint MAX_DUR = longint'(1) << CNT_W;

  if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 ||
      ALLRED_CYCLES < 1 || WALK_CYCLES < 1 ||
      FLASH_HALF < 1) begin : g_bad_min
    $error("traffic_light_ctrl: durations must be >= 1");
  end

  if (MIN_GREEN < 1 || MIN_GREEN > GREEN_CYCLES) begin : g_bad_mg
    $error("traffic_light_ctrl: need 1 <= MIN_GREEN <= GREEN_CYCLES");
  end

  if (GREEN_CYCLES > MAX_DUR || YELLOW_CYCLES > MAX_DUR ||
      ALLRED_CYCLES > MAX_DUR || WALK_CYCLES > MAX_DUR ||
      FLASH_HALF > MAX_DUR) begin : g_bad_max
    $error("traffic_light_ctrl: duration exceeds counter range");
  end

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] GREEN_CUT =
    CNT_W'(GREEN_CYCLES - MIN_GREEN);

  state_t           state_q;
  state_t           state_d;
  logic             ped_pend_q;
  logic             ped_pend_d;
  logic             walk_q;
  logic             walk_d;
  logic             blink_q;
  logic             blink_d;
  lights_t          lights_q;
  lights_t          lights_d;
  logic             ped_walk_q;
  logic             ped_walk_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .load    (ld),
    .load_val(ld_val),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  // walk_q marks a green that ended with a request pending; it selects
  // the walk all-red after the following yellow.
  always_comb begin
    state_d    = state_q;
    ped_pend_d = ped_pend_q | ped_req;
    walk_d     = walk_q;
    blink_d    = blink_q;
    ld         = 1'b0;
    ld_val     = '0;

    case (state_q)
      S_EW_GREEN, S_NS_GREEN: begin
        if (cnt_zero || (ped_pend_q && cnt <= GREEN_CUT)) begin
          state_d = (state_q == S_EW_GREEN) ? S_EW_YELLOW
                                            : S_NS_YELLOW;
          walk_d  = ped_pend_q;
          ld      = 1'b1;
          ld_val  = YELLOW_LD;
        end
      end
      S_EW_YELLOW, S_NS_YELLOW: begin
        if (cnt_zero) begin
          state_d = (state_q == S_EW_YELLOW) ? S_ALLRED_A
                                             : S_ALLRED_B;
          ld      = 1'b1;
          ld_val  = walk_q ? WALK_LD : ALLRED_LD;
          if (walk_q)
            ped_pend_d = 1'b0;
        end
      end
      S_ALLRED_A, S_ALLRED_B: begin
        if (walk_q)
          ped_pend_d = 1'b0;
        if (cnt_zero) begin
          walk_d = 1'b0;
          ld     = 1'b1;
          if (flash) begin
            state_d    = S_FLASH;
            ld_val     = FLASH_LD;
            blink_d    = 1'b0;
            ped_pend_d = 1'b0;
          end else begin
            state_d = (state_q == S_ALLRED_A) ? S_NS_GREEN
                                              : S_EW_GREEN;
            ld_val  = GREEN_LD;
          end
        end
      end
      S_FLASH: begin
        ped_pend_d = 1'b0;
        if (!flash) begin
          state_d = S_ALLRED_B;
          ld      = 1'b1;
          ld_val  = ALLRED_LD;
        end else if (cnt_zero) begin
          blink_d = ~blink_q;
          ld      = 1'b1;
          ld_val  = FLASH_LD;
        end
      end
      default: begin
        state_d    = S_EW_GREEN;
        ped_pend_d = 1'b0;
        walk_d     = 1'b0;
        blink_d    = 1'b0;
        ld         = 1'b1;
        ld_val     = GREEN_LD;
      end
    endcase

    if (!rst) begin
      state_d    = S_EW_GREEN;
      ped_pend_d = 1'b0;
      walk_d     = 1'b0;
      blink_d    = 1'b0;
      ld         = 1'b1;
      ld_val     = GREEN_LD;
    end

    lights_d   = state_lights(state_d, blink_d);
    ped_walk_d = walk_d &&
                 (state_d == S_ALLRED_A || state_d == S_ALLRED_B);
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    ped_pend_q <= ped_pend_d;
    walk_q     <= walk_d;
    blink_q    <= blink_d;
    lights_q   <= lights_d;
    ped_walk_q <= ped_walk_d;
  end

  assign e_west   = lights_q.ew;
  assign s_north  = lights_q.ns;
  assign ped_walk = ped_walk_q;
  assign remain   = cnt;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: default and shortened-timing instances
// against an elapsed-time phase model, directed then random stimulus.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash = 1'b0;

  logic [1:0] ew0, ns0, ew1, ns1;
  logic       wk0, wk1;
  logic [7:0] rm0, rm1;

  always #5 clk = ~clk;

  traffic_light_ctrl u_dflt (
    .clk     (clk),
    .rst     (rst),
    .ped_req (ped_req),
    .flash   (flash),
    .e_west  (ew0),
    .s_north (ns0),
    .ped_walk(wk0),
    .remain  (rm0)
  );

  traffic_light_ctrl #(
    .GREEN_CYCLES (3),
    .YELLOW_CYCLES(1),
    .ALLRED_CYCLES(1),
    .MIN_GREEN    (1),
    .WALK_CYCLES  (2),
    .FLASH_HALF   (2)
  ) u_small (
    .clk     (clk),
    .rst     (rst),
    .ped_req (ped_req),
    .flash   (flash),
    .e_west  (ew1),
    .s_north (ns1),
    .ped_walk(wk1),
    .remain  (rm1)
  );

  // durations per instance: green, yellow, allred, min green, walk, flash
  int p_g[2] = '{25, 3};
  int p_y[2] = '{5, 1};
  int p_a[2] = '{2, 1};
  int p_m[2] = '{10, 1};
  int p_w[2] = '{8, 2};
  int p_f[2] = '{4, 2};

  // phase: 0 EWG 1 EWY 2 ARA 3 NSG 4 NSY 5 ARB 6 FLASH
  int m_ph[2];
  int m_t[2];
  int m_dur[2];
  bit m_pend[2];
  bit m_walk[2];
  bit m_blink[2];

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic enter(input int i, input int ph, input int dur);
    m_ph[i]  = ph;
    m_dur[i] = dur;
    m_t[i]   = 0;
  endtask

  task automatic model_step(input int i, input bit r, input bit req,
                            input bit fl);
    bit np;
    if (!r) begin
      enter(i, 0, p_g[i]);
      m_pend[i]  = 0;
      m_walk[i]  = 0;
      m_blink[i] = 0;
      return;
    end
    np = m_pend[i] | req;
    case (m_ph[i])
      0, 3: begin
        if (m_t[i] == m_dur[i] - 1 ||
            (m_pend[i] && m_t[i] >= p_m[i] - 1)) begin
          m_walk[i] = m_pend[i];
          enter(i, m_ph[i] + 1, p_y[i]);
        end else m_t[i]++;
      end
      1, 4: begin
        if (m_t[i] == m_dur[i] - 1) begin
          if (m_walk[i]) np = 0;
          enter(i, m_ph[i] + 1, m_walk[i] ? p_w[i] : p_a[i]);
        end else m_t[i]++;
      end
      2, 5: begin
        if (m_walk[i]) np = 0;
        if (m_t[i] == m_dur[i] - 1) begin
          m_walk[i] = 0;
          if (fl) begin
            np = 0;
            m_blink[i] = 0;
            enter(i, 6, p_f[i]);
          end else enter(i, (m_ph[i] + 1) % 6, p_g[i]);
        end else m_t[i]++;
      end
      default: begin
        np = 0;
        if (!fl) enter(i, 5, p_a[i]);
        else if (m_t[i] == m_dur[i] - 1) begin
          m_blink[i] = ~m_blink[i];
          m_t[i] = 0;
        end else m_t[i]++;
      end
    endcase
    m_pend[i] = np;
  endtask

  task automatic compare(input int i, input logic [1:0] ew,
                         input logic [1:0] ns, input logic wk,
                         input logic [7:0] rm);
    int eew, ens;
    case (m_ph[i])
      0: begin eew = 1; ens = 0; end
      1: begin eew = 2; ens = 0; end
      3: begin eew = 0; ens = 1; end
      4: begin eew = 0; ens = 2; end
      6: begin
        eew = m_blink[i] ? 3 : 2;
        ens = eew;
      end
      default: begin eew = 0; ens = 0; end
    endcase
    check($sformatf("e_west[%0d]", i), 32'(ew), eew);
    check($sformatf("s_north[%0d]", i), 32'(ns), ens);
    check($sformatf("ped_walk[%0d]", i), 32'(wk),
          int'((m_ph[i] == 2 || m_ph[i] == 5) && m_walk[i]));
    check($sformatf("remain[%0d]", i), 32'(rm),
          m_dur[i] - 1 - m_t[i]);
  endtask

  task automatic cyc(input bit r, input bit req, input bit fl);
    rst = r;
    ped_req = req;
    flash = fl;
    @(posedge clk);
    model_step(0, r, req, fl);
    model_step(1, r, req, fl);
    @(negedge clk);
    compare(0, ew0, ns0, wk0, rm0);
    compare(1, ew1, ns1, wk1, rm1);
  endtask

  // call k drives the inputs of cycle k-1 and checks cycle k
  initial begin
    bit fl;
    @(negedge clk);

    cyc(0, 0, 0);
    check("rst_ew", 32'(ew0), 1);
    check("rst_ns", 32'(ns0), 0);
    check("rst_remain", 32'(rm0), 24);
    check("rst_walk", 32'(wk0), 0);
    for (int k = 1; k <= 64; k++) begin
      cyc(1, 0, 0);
      if (k == 10) check("small_period", 32'(rm1), 2);
      if (k == 25) check("ew_yellow_25", 32'(ew0), 2);
      if (k == 32) check("ns_green_32", 32'(ns0), 1);
      if (k == 64) check("wrap_remain", 32'(rm0), 24);
    end

    cyc(0, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      cyc(1, k == 4, 0);
      if (k == 10) check("ped_yellow_10", 32'(ew0), 2);
      if (k == 15) check("ped_walk_15", 32'(wk0), 1);
      if (k == 23) check("ped_nsg_23", 32'(ns0), 1);
    end

    cyc(0, 0, 0);
    for (int k = 1; k <= 90; k++) begin
      cyc(1, k == 21 || k == 30, 0);
      if (k == 22) check("late_ped_yel", 32'(ew0), 2);
      if (k == 27) check("late_walk", 32'(wk0), 1);
    end

    cyc(0, 0, 0);
    for (int k = 1; k <= 70; k++) begin
      cyc(1, k == 34, k >= 6 && k <= 44);
      if (k == 32) check("flash_yel", 32'(ns0), 2);
      if (k == 36) check("flash_off", 32'(ew0), 3);
      if (k == 45) check("flash_exit", 32'(ew0), 0);
      if (k == 47) check("flash_ewg", 32'(ew0), 1);
    end

    cyc(0, 0, 0);
    for (int k = 1; k <= 100; k++) begin
      cyc(k != 60, k == 58, 0);
      if (k == 60) check("midrst_remain", 32'(rm0), 24);
      if (k == 84) check("midrst_full", 32'(ew0), 1);
      if (k == 85) check("midrst_yel", 32'(ew0), 2);
    end

    fl = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 149) == 0) fl = ~fl;
      cyc($urandom_range(0, 299) != 0,
          $urandom_range(0, 19) == 0, fl);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
